// File: rtl/lc3b_types_pkg.sv
// Shared types and width helpers for the memory-stage bus port.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_port_state_t;

  function automatic int unsigned word_bytes(input int unsigned word_w);
    return word_w / 8;
  endfunction

  // Width of the word index within a line; at least one bit so it stays a legal vector.
  function automatic int unsigned lane_idx_w(input int unsigned word_w, input int unsigned line_w);
    return (line_w / word_w > 1) ? $clog2(line_w / word_w) : 1;
  endfunction

  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_stage_port_line_lane_select.sv
// Word/byte lane steering between a datapath word and a wishbone line.
module line_lane_select
  import lc3b_types::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WORD_W/8-1:0] byte_en,
  input  logic [WORD_W-1:0]   wdata,
  input  logic [LINE_W-1:0]   line,
  output logic [LINE_W/8-1:0] sel,
  output logic [LINE_W-1:0]   line_wdata,
  output logic [WORD_W-1:0]   rdata
);

  localparam int unsigned WB     = word_bytes(WORD_W);
  localparam int unsigned LB     = LINE_W / 8;
  localparam int unsigned NWORDS = LINE_W / WORD_W;
  localparam int unsigned IW     = lane_idx_w(WORD_W, LINE_W);
  localparam int unsigned OFF_W  = $clog2(WB);

  logic [IW-1:0] idx;

  // Masking with NWORDS-1 also yields idx=0 when the line holds a single word.
  assign idx        = IW'((addr >> OFF_W) & ADDR_W'(NWORDS - 1));
  assign sel        = LB'(byte_en) << (WB * 32'(idx));
  assign line_wdata = LINE_W'(wdata) << (WORD_W * 32'(idx));
  assign rdata      = WORD_W'(line >> (WORD_W * 32'(idx)));

endmodule

// File: rtl/mem_stage_port.sv
// Memory-stage wishbone port: holds a load/store on the bus until ACK or
// timeout, stalling the pipeline, with misalignment and flush handling.
module mem_stage_port
  import lc3b_types::*;
#(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [WORD_W/8-1:0] req_byte_en,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                stall,
  output logic                rsp_valid,
  output logic [WORD_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   wb_adr,
  output logic [LINE_W-1:0]   wb_dat_m,
  input  logic [LINE_W-1:0]   wb_dat_s,
  output logic [LINE_W/8-1:0] wb_sel,
  output logic                wb_we,
  output logic                wb_stb,
  output logic                wb_cyc,
  input  logic                wb_ack
);

  localparam int unsigned WB      = word_bytes(WORD_W);
  localparam int unsigned LB      = LINE_W / 8;
  localparam int unsigned CNT_W   = wait_cnt_w(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  mem_port_state_t state, state_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              kill, kill_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [WORD_W-1:0] rsp_rdata_d;
  logic [ADDR_W-1:0] wb_adr_d;
  logic [LINE_W-1:0] wb_dat_m_d;
  logic [LB-1:0]     wb_sel_d;
  logic              wb_we_d, wb_cyc_d;

  logic [ADDR_W-1:0] lane_addr;
  logic [LB-1:0]     lane_sel;
  logic [LINE_W-1:0] lane_wdata;
  logic [WORD_W-1:0] lane_rdata;
  logic              misaligned;
  logic              timeout_hit;
  logic              killed;

  // Steering uses the incoming request in IDLE and the held address while on the bus.
  assign lane_addr = (state == IDLE) ? req_addr : wb_adr;

  line_lane_select #(
    .WORD_W (WORD_W),
    .LINE_W (LINE_W),
    .ADDR_W (ADDR_W)
  ) u_lane (
    .addr       (lane_addr),
    .byte_en    (req_byte_en),
    .wdata      (req_wdata),
    .line       (wb_dat_s),
    .sel        (lane_sel),
    .line_wdata (lane_wdata),
    .rdata      (lane_rdata)
  );

  assign misaligned  = (&req_byte_en) && ((req_addr & ADDR_W'(WB - 1)) != '0);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));
  assign killed      = kill | flush;

  assign stall  = ~rst & req_valid & ~flush & (state != DONE);
  assign wb_stb = wb_cyc;

  // Next-state and next-register values.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    kill_d      = kill;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    wb_adr_d    = wb_adr;
    wb_dat_m_d  = wb_dat_m;
    wb_sel_d    = wb_sel;
    wb_we_d     = wb_we;
    wb_cyc_d    = wb_cyc;

    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          wb_adr_d   = req_addr;
          wb_we_d    = req_write;
          wb_sel_d   = lane_sel;
          wb_dat_m_d = lane_wdata;
          cnt_d      = '0;
          kill_d     = 1'b0;
          if (misaligned) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d  = BUSY;
            wb_cyc_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt != {CNT_W{1'b1}}) cnt_d = cnt + CNT_W'(1);
        if (flush) kill_d = 1'b1;
        // ACK takes priority over a timeout landing in the same cycle.
        if (wb_ack) begin
          state_d     = DONE;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = ~killed;
          rsp_rdata_d = lane_rdata;
        end else if (timeout_hit) begin
          state_d     = DONE;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = ~killed;
          rsp_err_d   = ~killed;
          rsp_rdata_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        kill_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d  = IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      kill      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wb_adr    <= '0;
      wb_dat_m  <= '0;
      wb_sel    <= '0;
      wb_we     <= 1'b0;
      wb_cyc    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      kill      <= kill_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      wb_adr    <= wb_adr_d;
      wb_dat_m  <= wb_dat_m_d;
      wb_sel    <= wb_sel_d;
      wb_we     <= wb_we_d;
      wb_cyc    <= wb_cyc_d;
    end
  end

endmodule

// File: doc/mem_stage_port.md
Name: mem_stage_port

Overview:
Parametrised memory-stage bus port that sits between the EX/MEM pipeline register and the wishbone data master.
It is the successor to the fixed 16-bit-word / 128-bit-line, ack-less memory hookup.
- Holds each load/store request on the bus until WB ACK or timeout, stalling the pipeline meanwhile.
- Does word/byte lane steering for any line/word width.
- Reports misalignment/timeout errors and supports flush of an in-flight access.

Parameters:
WORD_W, 16, datapath word width in bits (multiple of 8)
LINE_W, 128, wishbone data width in bits (power-of-2 multiple of WORD_W)
ADDR_W, 16, byte address width
TIMEOUT, 0, max BUSY cycles waiting for ACK; 0 = wait forever

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  EX/MEM holds a load or store
req_write  in  1  1 = store, 0 = load
req_byte_en  in  WORD_W/8  byte enables within the word (all ones = word access)
req_addr  in  ADDR_W  byte address
req_wdata  in  WORD_W  store data, right-aligned
flush  in  1  squash current request (branch redirect)
stall  out  1  hold PC and all pipeline registers
rsp_valid  out  1  access completed this cycle
rsp_rdata  out  WORD_W  load data word, lane-extracted
rsp_err  out  1  misaligned or timed-out access
wb_adr  out  ADDR_W  registered request address
wb_dat_m  out  LINE_W  store data shifted to its lane
wb_dat_s  in  LINE_W  read line
wb_sel  out  LINE_W/8  byte select
wb_we  out  1  write enable
wb_stb  out  1  strobe
wb_cyc  out  1  cycle
wb_ack  in  1  slave acknowledge

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Derived: WB = WORD_W/8, IDX = addr[log2(LINE_W/8)-1 : log2(WB)].
- Lane steering:
  - wb_sel = byte_en << (WB*IDX)
  - wb_dat_m = wdata << (WORD_W*IDX)
  - read word = wb_dat_s >> (WORD_W*IDX)
- Misalignment: req_byte_en all ones with req_addr[log2(WB)-1:0] != 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On req_valid & ~flush: latch addr/we/sel/wdata into request registers.
  - If misaligned: go to DONE with err=1 and no bus cycle.
  - Otherwise: go to BUSY.
- BUSY:
  - wb_cyc = wb_stb = 1; wb_adr/wb_sel/wb_we/wb_dat_m driven from registers, stable all of BUSY.
  - Wait counter increments each BUSY cycle.
  - On wb_ack: capture read word into rsp register, go to DONE with err=0.
  - If TIMEOUT != 0 and counter reaches TIMEOUT without ack: drop cyc/stb, go to DONE with err=1, rdata=0.
  - ACK in the same cycle as timeout wins (err=0).
- DONE:
  - rsp_valid = 1 unless killed; rsp_rdata/rsp_err valid.
  - stall = 0; unconditionally return to IDLE next cycle.
- stall = req_valid & ~flush & (state != DONE), combinational.
  - Result: a request whose ACK arrives in the n-th BUSY cycle stalls n+1 cycles, and rsp_valid appears in cycle n+1 after the request is presented.
- Flush:
  - In IDLE: no bus cycle is started.
  - In BUSY: the bus cycle still completes (no mid-cycle abort); a kill flag is set and DONE suppresses rsp_valid/rsp_err. The kill flag clears on DONE exit.
- Reset values: state=IDLE, wb_cyc=wb_stb=wb_we=0, wb_sel=0, wb_adr=0, wb_dat_m=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, kill=0. stall is 0 while in reset.
- Reset mid-BUSY: cyc/stb fall on the following edge; the outstanding ACK is ignored.
- Stray wb_ack in IDLE/DONE is ignored.
- Counter saturates; width is clog2(TIMEOUT+1), minimum 1.

Decomposition:
- Shared package (lc3b_types): enum mem_port_state_t {IDLE, BUSY, DONE}; functions for lane index width and byte count derived from WORD_W/LINE_W.
- One sub-module: line_lane_select. Combinational, parametrised WORD_W/LINE_W/ADDR_W. Produces sel, shifted wdata, and extracted read word from addr, byte_en, wdata, and line.
- The FSM, counter and request/response registers stay in mem_stage_port.

Test Plan:
- Word load at addr 0x0046, wb_dat_s word3=0xBEEF, ack in 2nd BUSY cycle -> wb_sel=0x00C0, wb_we=0, stall high 3 cycles, rsp_valid 1 cycle with rsp_rdata=0xBEEF, rsp_err=0.
- Byte store at addr 0x001B, byte_en=2'b10, wdata=0x12AB, immediate ack -> wb_sel=0x0800, wb_dat_m=0x12AB<<80, wb_we=1, stall 2 cycles.
- Word load at odd addr 0x0047 -> no wb_cyc ever, stall 1 cycle, rsp_valid with rsp_err=1.
- TIMEOUT=8, no ack -> wb_cyc high exactly 8 cycles, then rsp_valid, rsp_err=1, rsp_rdata=0.
- Flush asserted in 1st BUSY cycle, ack in 3rd -> cyc held until ack, rsp_valid never asserts, stall low from flush onward.
- rst asserted in 2nd BUSY cycle, then ack -> wb_cyc=0 after the edge, all outputs at reset values, no rsp_valid.
